// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-port arbiter for the 32x32 register file, with a registered write command.
// Optional macro WB_RR_EN selects round-robin on contention; otherwise req0 has fixed priority.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic              contend, gnt0, gnt1, xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef WB_RR_EN
   logic              last_q, last_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      contend = req0_valid & req1_valid;
`ifdef WB_RR_EN
      // req1 wins a contended cycle only when req0 was the last one served
      gnt1 = req1_valid & (~req0_valid | ~last_q);
`else
      gnt1 = req1_valid & ~req0_valid;
`endif
      gnt0     = req0_valid & ~gnt1;
      xfer     = (gnt0 | gnt1) & ~rst;
      sel_addr = gnt1 ? req1_addr : req0_addr;
      sel_data = gnt1 ? req1_data : req0_data;

      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      cnt_d  = contend ? sat_inc(cnt_q) : cnt_q;
`ifdef WB_RR_EN
      last_d = last_q;
`endif
      if (xfer) begin
         // r0 writes are acknowledged but never enabled
         we_d   = (sel_addr != '0);
         addr_d = sel_addr;
         data_d = sel_data;
`ifdef WB_RR_EN
         last_d = gnt1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
`ifdef WB_RR_EN
         last_q <= 1'b1;
`endif
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
`ifdef WB_RR_EN
         last_q <= last_d;
`endif
      end
   end

   assign req0_ready   = gnt0 & ~rst;
   assign req1_ready   = gnt1 & ~rst;
   assign RegWrite     = we_q;
   assign WriteAddr    = addr_q;
   assign WriteData    = data_q;
   assign conflict_cnt = cnt_q;

endmodule
